// File: rtl/ram_sp_be_ctl.sv
// Single-port SRAM with per-column write enables, a registered read and a self-clearing engine.
// Read latency 1 cycle (2 with RAM_SP_BE_OREG_EN defined: extra output pipeline register).
// No backpressure: accesses are accepted every cycle unless busy_o, when they are dropped.
module ram_sp_be_ctl #(
    parameter int                    ADR_WD  = 6,
    parameter int                    DAT_WD  = 23,
    parameter int                    COL_WD  = 23,
    parameter logic [DAT_WD-1:0]     CLR_VAL = '0
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   clr_i,
    input  logic [ADR_WD-1:0]                      adr_i,
    input  logic [(DAT_WD+COL_WD-1)/COL_WD-1:0]    wr_ena_i,
    input  logic [DAT_WD-1:0]                      wr_dat_i,
    input  logic                                   rd_ena_i,
    output logic [DAT_WD-1:0]                      rd_dat_o,
    output logic                                   rd_val_o,
    output logic                                   busy_o
);

    localparam int                COL_NUM = (DAT_WD + COL_WD - 1) / COL_WD;
    localparam int                DEPTH   = 2 ** ADR_WD;
    localparam logic [ADR_WD-1:0] ADR_MAX = '1;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [ADR_WD-1:0]   cnt_q;
    logic [ADR_WD-1:0]   cnt_d;
    logic [DAT_WD-1:0]   mem [DEPTH];
    logic [DAT_WD-1:0]   wr_mask;
    logic                usr_wr;
    logic                usr_rd;
    logic [DAT_WD-1:0]   rd_dat_q;
    logic                rd_val_q;

    // Expand column enables to a bit mask; the last column simply covers fewer bits.
    for (genvar b = 0; b < DAT_WD; b++) begin : g_mask
        assign wr_mask[b] = wr_ena_i[b / COL_WD];
    end

    // User accesses only count in IDLE; a write in the same cycle suppresses the read.
    assign usr_wr = (state_q == IDLE) && (|wr_ena_i);
    assign usr_rd = (state_q == IDLE) && rd_ena_i && !(|wr_ena_i);
    assign busy_o = (state_q == CLEAR);

    // State and clear-counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: sweep every address once, compare to the last address so the counter never wraps unnoticed.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            CLEAR: begin
                if (clr_i) begin
                    cnt_d = '0;
                end else if (cnt_q == ADR_MAX) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            IDLE: begin
                if (clr_i) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    // Array write port: clear engine owns the port while busy, otherwise masked user writes.
    always_ff @(posedge clk) begin
        if (state_q == CLEAR) begin
            mem[cnt_q] <= CLR_VAL;
        end else if (usr_wr) begin
            mem[adr_i] <= (mem[adr_i] & ~wr_mask) | (wr_dat_i & wr_mask);
        end
    end

    // Registered read: data holds between reads, valid pulses for one cycle per accepted read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_dat_q <= '0;
            rd_val_q <= 1'b0;
        end else begin
            rd_val_q <= usr_rd;
            if (usr_rd) begin
                rd_dat_q <= mem[adr_i];
            end
        end
    end

`ifdef RAM_SP_BE_OREG_EN
    logic [DAT_WD-1:0] rd_dat_p;
    logic              rd_val_p;

    // Extra output stage: data and valid move together, so a read in flight survives a clear request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_dat_p <= '0;
            rd_val_p <= 1'b0;
        end else begin
            rd_dat_p <= rd_dat_q;
            rd_val_p <= rd_val_q;
        end
    end

    assign rd_dat_o = rd_dat_p;
    assign rd_val_o = rd_val_p;
`else
    assign rd_dat_o = rd_dat_q;
    assign rd_val_o = rd_val_q;
`endif

endmodule
